// File: rtl/bram_8192x2.sv
// 8192x2 dual-port synchronous RAM with per-bit write masks and read-first ports.
// Same-address double writes merge bit by bit, and port 0 wins bits both ports write.
module bram_8192x2 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE0,
  input  logic [12:0] A0,
  input  logic [1:0]  D0,
  input  logic        WE0,
  input  logic [1:0]  WEM0,
  output logic [1:0]  Q0,
  input  logic        CE1,
  input  logic [12:0] A1,
  input  logic [1:0]  D1,
  input  logic        WE1,
  input  logic [1:0]  WEM1,
  output logic [1:0]  Q1
);

  logic [1:0] mem [8192] = '{default: 2'b00};

  logic       act0, act1;
  logic [1:0] m0, m1;
  logic       same;

  assign act0 = CE0 && !RST;
  assign act1 = CE1 && !RST;
  assign m0   = (act0 && WE0) ? WEM0 : 2'b00;
  assign m1   = (act1 && WE1) ? WEM1 : 2'b00;
  assign same = (A0 == A1);

  // Reads sample the pre-edge contents, so every port is read-first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q0 <= 2'b00;
      Q1 <= 2'b00;
    end else begin
      if (act0) Q0 <= mem[A0];
      if (act1) Q1 <= mem[A1];
    end
  end

  always_ff @(posedge CLK) begin
    if (same && (m0 != 2'b00) && (m1 != 2'b00)) begin
      mem[A0] <= (mem[A0] & ~(m0 | m1)) | (D0 & m0) | (D1 & m1 & ~m0);
    end else begin
      if (m0 != 2'b00) mem[A0] <= (mem[A0] & ~m0) | (D0 & m0);
      if (m1 != 2'b00) mem[A1] <= (mem[A1] & ~m1) | (D1 & m1);
    end
  end

endmodule

// File: tb/tb_bram_8192x2.sv
// Directed self-checking bench for bram_8192x2 with hand-computed expectations.
module tb_bram_8192x2;
  logic        CLK = 1'b0;
  logic        RST;
  logic        CE0, WE0, CE1, WE1;
  logic [12:0] A0, A1;
  logic [1:0]  D0, WEM0, D1, WEM1;
  logic [1:0]  Q0, Q1;
  int          n_chk = 0;
  int          n_err = 0;

  bram_8192x2 dut (
    .CLK(CLK), .RST(RST),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(Q0),
    .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    CE0 = 0; WE0 = 0; WEM0 = 2'b00; D0 = 2'b00; A0 = '0;
    CE1 = 0; WE1 = 0; WEM1 = 2'b00; D1 = 2'b00; A1 = '0;
  endtask

  task automatic wr0(input logic [12:0] a, input logic [1:0] d, input logic [1:0] m);
    idle();
    CE0 = 1; WE0 = 1; A0 = a; D0 = d; WEM0 = m;
    tick();
    idle();
  endtask

  task automatic rd0(input string tag, input logic [12:0] a, input logic [1:0] exp);
    idle();
    CE0 = 1; A0 = a;
    tick();
    chk(tag, Q0, exp);
    idle();
  endtask

  task automatic rd1(input string tag, input logic [12:0] a, input logic [1:0] exp);
    idle();
    CE1 = 1; A1 = a;
    tick();
    chk(tag, Q1, exp);
    idle();
  endtask

  initial begin
    idle();
    RST = 1;
    tick(); tick();
    chk("rst_q0", Q0, 2'b00);
    chk("rst_q1", Q1, 2'b00);
    RST = 0;

    rd0("init_zero", 13'h0500, 2'b00);

    // basic write/read at both address extremes
    wr0(13'h0000, 2'b10, 2'b11);
    wr0(13'h1FFF, 2'b01, 2'b11);
    rd1("basic_lo", 13'h0000, 2'b10);
    rd1("basic_hi", 13'h1FFF, 2'b01);

    // bit mask
    wr0(13'h0123, 2'b11, 2'b11);
    wr0(13'h0123, 2'b00, 2'b01);
    rd0("mask_01", 13'h0123, 2'b10);
    wr0(13'h0123, 2'b01, 2'b00);
    rd0("mask_00", 13'h0123, 2'b10);
    idle(); CE0 = 1; WE0 = 0; A0 = 13'h0123; D0 = 2'b01; WEM0 = 2'b11;
    tick(); idle();
    rd0("we_off", 13'h0123, 2'b10);

    // read-first across ports
    wr0(13'h0042, 2'b01, 2'b11);
    idle();
    CE0 = 1; WE0 = 1; A0 = 13'h0042; D0 = 2'b10; WEM0 = 2'b11;
    CE1 = 1; A1 = 13'h0042;
    tick();
    chk("rf_cross", Q1, 2'b01);
    rd0("rf_cross_new", 13'h0042, 2'b10);

    // read-first on the writing port
    wr0(13'h0043, 2'b01, 2'b11);
    idle();
    CE0 = 1; WE0 = 1; A0 = 13'h0043; D0 = 2'b10; WEM0 = 2'b11;
    tick();
    chk("rf_self_old", Q0, 2'b01);
    rd0("rf_self_new", 13'h0043, 2'b10);

    // same-address collision merges per bit
    idle();
    CE0 = 1; WE0 = 1; A0 = 13'h0777; D0 = 2'b11; WEM0 = 2'b01;
    CE1 = 1; WE1 = 1; A1 = 13'h0777; D1 = 2'b00; WEM1 = 2'b11;
    tick();
    rd1("collide", 13'h0777, 2'b01);

    // simultaneous writes to different addresses, then dual read
    idle();
    CE0 = 1; WE0 = 1; A0 = 13'h0100; D0 = 2'b11; WEM0 = 2'b11;
    CE1 = 1; WE1 = 1; A1 = 13'h0101; D1 = 2'b10; WEM1 = 2'b11;
    tick();
    idle();
    CE0 = 1; A0 = 13'h0100; CE1 = 1; A1 = 13'h0101;
    tick();
    chk("dual_q0", Q0, 2'b11);
    chk("dual_q1", Q1, 2'b10);

    // chip-enable hold
    rd1("hold_pre", 13'h0000, 2'b10);
    for (int i = 0; i < 5; i++) begin
      idle();
      A1 = 13'(i * 7 + 1);
      WE1 = 1; D1 = 2'b01; WEM1 = 2'b11;
      if (i == 0) begin
        CE0 = 1; WE0 = 1; A0 = 13'h0000; D0 = 2'b11; WEM0 = 2'b11;
      end
      tick();
      chk($sformatf("hold_%0d", i), Q1, 2'b10);
    end
    idle();
    CE0 = 0; WE0 = 1; A0 = 13'h1FFF; D0 = 2'b10; WEM0 = 2'b11;
    tick();
    rd0("ce_off_wr", 13'h1FFF, 2'b01);
    rd1("ce_hold_wr", 13'h0000, 2'b11);

    // reset with a concurrent write; Q0=01 and Q1=11 going in
    idle();
    RST = 1;
    CE0 = 1; WE0 = 1; A0 = 13'h0123; D0 = 2'b01; WEM0 = 2'b11;
    CE1 = 1; A1 = 13'h0042;
    tick();
    RST = 0;
    chk("rst_mid_q0", Q0, 2'b00);
    chk("rst_mid_q1", Q1, 2'b00);
    idle();
    tick();
    chk("rst_q0_hold", Q0, 2'b00);
    idle();
    CE0 = 1; A0 = 13'h0123; CE1 = 1; A1 = 13'h1FFF;
    tick();
    chk("rst_drop_wr", Q0, 2'b10);
    chk("rst_keep", Q1, 2'b01);
    rd0("rst_keep_42", 13'h0042, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bram_8192x2.md
# bram_8192x2

Dual-port synchronous block RAM, 8192 words × 2 bits, with a per-bit write mask on each port. It is the leaf storage primitive that wider and deeper SRAM wrappers tile together. Typically one port writes and the other reads, but both ports support both reads and writes. All operations are registered on a single clock, and read data appears one cycle after the access.

## Interface
- No parameters: geometry is fixed at 8192 words (13-bit address) × 2 bits.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- CE0  input  1  port 0 chip enable.
- A0  input  13  port 0 word address.
- D0  input  2  port 0 write data.
- WE0  input  1  port 0 write enable.
- WEM0  input  2  port 0 bit write mask; 1 means write that bit.
- Q0  output  2  port 0 registered read data.
- CE1, A1, D1, WE1, WEM1, Q1: the same as port 0, for port 1.

## Operation
- Storage: array mem[0..8191] of 2-bit words. Every word is 0 at time zero. Reset does not clear the array.
- Port p is active in a cycle when CEp=1 and RST=0. An inactive port neither reads nor writes, and its Qp holds its last value.
- Read: an active port always reads. Qp receives mem[Ap] as it was before this edge's writes (read-first), whether or not the port writes in the same cycle.
- Write: an active port with WEp=1 writes bit i of mem[Ap] with Dp[i] for each i where WEMp[i]=1. Unmasked bits keep their value. With WEp=0, WEMp and Dp are ignored.
- Write, same address, both ports: bits written by both ports take port 0's data. Bits written by only one port take that port's data.
- Read on one port while the other port writes the same address: the reader returns the old data.
- Address range: all 13-bit values are valid. There is no wrap or out-of-range case.

## Timing
- Read latency: 1 cycle. With CEp=1 at edge k, Qp is valid after edge k and holds until the next active edge of that port or a reset.
- Write latency: 1 cycle. Data written at edge k is readable by a read issued at edge k+1, with Q valid after edge k+1.
- Reset: on an edge with RST=1, Q0 and Q1 go to 2'b00 and all reads and writes are suppressed. Array contents are preserved.
- Reset mid-operation: an access presented in the same cycle as RST=1 has no effect. Accesses resume on the first edge with RST=0.
- No combinational path from any input to Q0 or Q1.

## Test plan
- Basic write/read:
  - Port 0 writes A0=0x0000 D0=2'b10 WEM0=2'b11, then A0=0x1FFF D0=2'b01.
  - Port 1 then reads A1=0x0000 and A1=0x1FFF.
  - Q1 is 2'b10 then 2'b01, each one cycle after its read.
- Bit mask:
  - Write 2'b11 to address 0x0123.
  - Write D0=2'b00 with WEM0=2'b01.
  - A read returns 2'b10. Writing with WEM0=2'b00 changes nothing.
- Read-first, both cases:
  - Address 0x0042 holds 2'b01. At one edge, port 0 writes 2'b10 there while port 1 reads it: Q1=2'b01.
  - Port 0 writes and reads the same address at one edge: Q0 shows the old value. A next-cycle read shows 2'b10.
- Collision:
  - Both ports write address 0x0777 at one edge: port 0 D0=2'b11 WEM0=2'b01, port 1 D1=2'b00 WEM1=2'b11.
  - A subsequent read returns 2'b01: bit 0 from port 0, bit 1 from port 1.
- Chip enable and hold:
  - After a read yields Q1=2'b10, drive CE1=0 for 5 cycles while A1 and memory change.
  - Q1 stays 2'b10. A write with CE0=0 and WE0=1 does not modify memory.
- Reset:
  - With Q0 and Q1 nonzero, assert RST for 1 cycle together with a port 0 write.
  - Q0 and Q1 become 2'b00, the write is dropped, and previously stored words read back unchanged after reset.
